flag_event_reader: RTL and testbench

- Consumer end of the sticky set/reset flag registers: scans N sticky status flags, reports one set flag at a time over a valid/ready handshake, then issues a one-cycle clear pulse back to that flag's register.
- Round-robin selection prevents starvation.
- Sits between a bank of flag registers (set by the event source, cleared by this block) and a downstream status/interrupt consumer.

---
 rtl/flag_reader_pkg.sv | 25 ++
 rtl/rr_pick.sv | 44 ++++
 rtl/flag_event_reader.sv | 92 +++++++++
 tb/tb_flag_event_reader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flag_reader_pkg.sv
// ---------------------------------------------------------------------------
// flag_reader_pkg : shared state encoding and one-hot helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package flag_reader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    localparam int C_MAX_FLAGS = 256;

    // Callers narrow the result to their own flag count with a size cast.
    function automatic logic [C_MAX_FLAGS-1:0] onehot(input logic [7:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin picker, first request at or above ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter  int N_FLAGS = 8,
    localparam int IDX_W   = $clog2(N_FLAGS)
) (
    input  logic [N_FLAGS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [2*N_FLAGS-1:0] w_dbl;
    logic [2*N_FLAGS-1:0] w_masked;
    logic                 w_found;

    // The upper copy supplies the wrapped-around candidates below ptr.
    assign w_dbl = {req, req};
    assign any   = |req;

    always_comb begin
        for (int i = 0; i < 2*N_FLAGS; i++) begin
            w_masked[i] = w_dbl[i] && (i >= int'(ptr));
        end
    end

    always_comb begin
        idx     = '0;
        w_found = 1'b0;
        for (int i = 0; i < 2*N_FLAGS; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found = 1'b1;
                idx     = IDX_W'(i % N_FLAGS);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/flag_event_reader.sv
// ---------------------------------------------------------------------------
// flag_event_reader : reports sticky flags one at a time, then clears them
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module flag_event_reader
    import flag_reader_pkg::*;
#(
    parameter  int N_FLAGS = 8,
    localparam int IDX_W   = $clog2(N_FLAGS),
    parameter  int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic [N_FLAGS-1:0] i_flags,
    output logic [N_FLAGS-1:0] o_clr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [IDX_W-1:0]   o_idx,
    output logic [CNT_W-1:0]   o_evt_cnt,
    output logic               o_busy
);

    localparam logic [CNT_W-1:0] C_CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_FLAGS - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic               w_any;
    logic [IDX_W-1:0]   w_pick;

    rr_pick #(
        .N_FLAGS (N_FLAGS)
    ) u_pick (
        .req (i_flags),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_pick)
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            o_valid   <= 1'b0;
            o_clr     <= '0;
            o_idx     <= '0;
            o_evt_cnt <= '0;
            o_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_clr <= '0;
                    if (w_any) begin
                        o_idx   <= w_pick;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        r_state <= PRESENT;
                    end
                end
                // Flag activity is ignored here: the captured index is reported
                // even if its flag has since dropped.
                PRESENT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_clr   <= N_FLAGS'(onehot(8'(o_idx)));
                        r_ptr   <= (o_idx == C_LAST_IDX) ? '0 : o_idx + 1'b1;
                        if (o_evt_cnt != C_CNT_MAX) begin
                            o_evt_cnt <= o_evt_cnt + 1'b1;
                        end
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    o_clr   <= '0;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    o_clr   <= '0;
                    o_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_flag_event_reader.sv
// ---------------------------------------------------------------------------
// tb_flag_event_reader : vector-table bench with a clear-wins flag register model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_flag_event_reader;

    typedef struct {
        logic [7:0]  set;
        logic        rdy;
        logic        ev;
        logic [2:0]  ei;
        logic [7:0]  ec;
        logic        eb;
        logic [15:0] ecnt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  set_bits;
    logic [7:0]  force_bits;
    logic [7:0]  fr;
    logic [7:0]  flags;
    logic [7:0]  clr;
    logic        valid;
    logic        ready;
    logic [2:0]  idx;
    logic [15:0] cnt;
    logic        busy;

    logic [7:0]  set2;
    logic [7:0]  fr2;
    logic [7:0]  clr2;
    logic        valid2;
    logic        ready2;
    logic [2:0]  idx2;
    logic [1:0]  cnt2;
    logic        busy2;

    int n_cmp;
    int n_err;
    vec_t vt [29];

    flag_event_reader #(.N_FLAGS(8), .CNT_W(16)) dut (
        .i_clk     (clk),
        .i_arst_n  (rst_n),
        .i_flags   (flags),
        .o_clr     (clr),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_idx     (idx),
        .o_evt_cnt (cnt),
        .o_busy    (busy)
    );

    flag_event_reader #(.N_FLAGS(8), .CNT_W(2)) dut_sat (
        .i_clk     (clk),
        .i_arst_n  (rst_n),
        .i_flags   (fr2),
        .o_clr     (clr2),
        .o_valid   (valid2),
        .i_ready   (ready2),
        .o_idx     (idx2),
        .o_evt_cnt (cnt2),
        .o_busy    (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign flags = fr | force_bits;

    // Flag registers: set by the event source, clear pulse wins.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr  <= '0;
            fr2 <= '0;
        end else begin
            fr  <= (fr | set_bits) & ~clr;
            fr2 <= (fr2 | set2) & ~clr2;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (!$onehot0(clr)) begin
                n_err++;
                $display("FAIL clr_onehot: got %0h required one-hot or zero", clr);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        set_bits   = '0;
        force_bits = '0;
        ready      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_rows(input int first, input int count);
        for (int r = first; r < first + count; r++) begin
            set_bits = vt[r].set;
            ready    = vt[r].rdy;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d_valid", r), 32'(valid), 32'(vt[r].ev));
            check($sformatf("row%0d_idx",   r), 32'(idx),   32'(vt[r].ei));
            check($sformatf("row%0d_clr",   r), 32'(clr),   32'(vt[r].ec));
            check($sformatf("row%0d_busy",  r), 32'(busy),  32'(vt[r].eb));
            check($sformatf("row%0d_cnt",   r), 32'(cnt),   32'(vt[r].ecnt));
        end
        set_bits = '0;
    endtask

    initial begin
        int sat_exp [5];
        int t;
        sat_exp = '{1, 2, 3, 3, 3};
        n_cmp = 0;
        n_err = 0;

        // single event {set, rdy, valid, idx, clr, busy, cnt}
        vt[0]  = '{8'h04, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd0};
        vt[1]  = '{8'h00, 1'b1, 1'b1, 3'd2, 8'h00, 1'b1, 16'd0};
        vt[2]  = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h04, 1'b1, 16'd1};
        vt[3]  = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 16'd1};
        vt[4]  = '{8'h00, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 16'd1};
        // round-robin with wrap, flags 0x81 re-set every cycle
        vt[5]  = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd0};
        vt[6]  = '{8'h81, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 16'd0};
        vt[7]  = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, 16'd1};
        vt[8]  = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd1};
        vt[9]  = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h00, 1'b1, 16'd1};
        vt[10] = '{8'h81, 1'b1, 1'b0, 3'd7, 8'h80, 1'b1, 16'd2};
        vt[11] = '{8'h81, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 16'd2};
        vt[12] = '{8'h81, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 16'd2};
        vt[13] = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1, 16'd3};
        vt[14] = '{8'h81, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 16'd3};
        vt[15] = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h00, 1'b1, 16'd3};
        vt[16] = '{8'h81, 1'b1, 1'b0, 3'd7, 8'h80, 1'b1, 16'd4};
        vt[17] = '{8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 16'd4};
        // backpressure, bit 4 arrives while index 3 is presented
        vt[18] = '{8'h08, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 16'd0};
        vt[19] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 16'd0};
        vt[20] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 16'd0};
        vt[21] = '{8'h10, 1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 16'd0};
        vt[22] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 16'd0};
        vt[23] = '{8'h00, 1'b0, 1'b1, 3'd3, 8'h00, 1'b1, 16'd0};
        vt[24] = '{8'h00, 1'b1, 1'b0, 3'd3, 8'h08, 1'b1, 16'd1};
        vt[25] = '{8'h00, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 16'd1};
        vt[26] = '{8'h00, 1'b1, 1'b1, 3'd4, 8'h00, 1'b1, 16'd1};
        vt[27] = '{8'h00, 1'b1, 1'b0, 3'd4, 8'h10, 1'b1, 16'd2};
        vt[28] = '{8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 16'd2};

        rst_n      = 1'b0;
        set_bits   = '0;
        force_bits = '0;
        ready      = 1'b0;
        set2       = '0;
        ready2     = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_clr",   32'(clr),   32'd0);
        check("rst_idx",   32'(idx),   32'd0);
        check("rst_cnt",   32'(cnt),   32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;

        run_rows(0, 5);
        do_reset();
        run_rows(5, 13);
        do_reset();
        run_rows(18, 11);

        // reset asserted in PRESENT (ptr=5, cnt=2 left by the previous block)
        set_bits = 8'h20;
        @(posedge clk);
        @(negedge clk);
        set_bits = '0;
        @(posedge clk);
        @(negedge clk);
        check("pres_valid", 32'(valid), 32'd1);
        check("pres_idx",   32'(idx),   32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("pres_rst_valid", 32'(valid), 32'd0);
        check("pres_rst_cnt",   32'(cnt),   32'd0);
        check("pres_rst_busy",  32'(busy),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("pres_rst_noclr",   32'(clr),   32'd0);
            check("pres_rst_novalid", 32'(valid), 32'd0);
        end

        // reset asserted in CLEAR aborts the pulse
        do_reset();
        set_bits = 8'h20;
        @(posedge clk);
        @(negedge clk);
        set_bits = '0;
        ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("clr_state_clr", 32'(clr), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        check("clr_rst_clr", 32'(clr), 32'd0);
        check("clr_rst_cnt", 32'(cnt), 32'd0);

        // asynchronous reset with all flags forced high
        do_reset();
        force_bits = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        check("ff_pre_valid", 32'(valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ff_rst_valid", 32'(valid), 32'd0);
        check("ff_rst_clr",   32'(clr),   32'd0);
        check("ff_rst_idx",   32'(idx),   32'd0);
        check("ff_rst_cnt",   32'(cnt),   32'd0);
        check("ff_rst_busy",  32'(busy),  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ff_rel_valid", 32'(valid), 32'd1);
        check("ff_rel_idx",   32'(idx),   32'd0);
        check("ff_rel_busy",  32'(busy),  32'd1);

        // saturating counter on the narrow instance
        do_reset();
        set2 = 8'h02;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            while (!valid2 && t < 10) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("sat%0d_valid_seen", k), 32'(valid2), 32'd1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("sat%0d_cnt", k), 32'(cnt2), 32'(sat_exp[k]));
        end
        set2 = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
